// File: rtl/decode_pkg.sv
// Shared constants for the RV32I decode stage: opcodes, ALU control codes,
// branch/jump type codes and the squash FSM state encoding.
package decode_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // ALU control is {funct7, funct3} of the equivalent R-type operation
  localparam logic [9:0] ALU_ADD  = 10'h000;
  localparam logic [9:0] ALU_SUB  = 10'h100;
  localparam logic [9:0] ALU_SLT  = 10'h002;
  localparam logic [9:0] ALU_SLTU = 10'h003;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] JT_JAL  = 3'b010;
  localparam logic [2:0] JT_JALR = 3'b011;

  typedef enum logic {ST_RUN = 1'b0, ST_DROP = 1'b1} state_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction -> decoded bundle translation.
// With DECODE_MEXT_EN defined, R-type funct7=0000001 (M extension) is legal.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic [31:0]      instr,
  output logic [9:0]       alu_ctrl,
  output logic [XLEN-1:0]  imm,
  output logic             imm_en,
  output logic [REG_W:0]   sel_a,
  output logic [REG_W-1:0] sel_b,
  output logic [REG_W:0]   sel_out,
  output logic             new_jmp,
  output logic [2:0]       jmp_type,
  output logic [XLEN-1:0]  jmp_imm,
  output logic [REG_W:0]   jal_rs,
  output logic             lam_new,
  output logic             lam_rw,
  output logic [2:0]       lam_type,
  output logic [REG_W-1:0] lam_rs,
  output logic [REG_W-1:0] lam_sel_out,
  output logic             illegal
);

  localparam logic [REG_W:0]  PC_SEL   = {1'b1, {REG_W{1'b0}}};
  localparam logic [XLEN-1:0] LINK_OFF = XLEN'(-4);

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [REG_W:0] rd_w, rs1_w;
  logic [REG_W-1:0] rd_n, rs2_n;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic r_legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd_w   = (REG_W+1)'(instr[11:7]);
  assign rs1_w  = (REG_W+1)'(instr[19:15]);
  assign rd_n   = REG_W'(instr[11:7]);
  assign rs2_n  = REG_W'(instr[24:20]);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

`ifdef DECODE_MEXT_EN
  assign r_legal = (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MEXT);
`else
  assign r_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
`endif

  // Illegal instructions leave every field at zero apart from the flag
  always_comb begin
    alu_ctrl    = ALU_ADD;
    imm         = '0;
    imm_en      = 1'b0;
    sel_a       = '0;
    sel_b       = '0;
    sel_out     = '0;
    new_jmp     = 1'b0;
    jmp_type    = 3'b000;
    jmp_imm     = '0;
    jal_rs      = '0;
    lam_new     = 1'b0;
    lam_rw      = 1'b0;
    lam_type    = 3'b000;
    lam_rs      = '0;
    lam_sel_out = '0;
    illegal     = 1'b0;
    case (opcode)
      OP_R: begin
        if (r_legal) begin
          alu_ctrl = {f7, f3};
          sel_a    = rs1_w;
          sel_b    = rs2_n;
          sel_out  = rd_w;
        end else begin
          illegal  = 1'b1;
        end
      end
      OP_IMM: begin
        alu_ctrl = (f3 == 3'b001 || f3 == 3'b101) ? {f7, f3} : {7'b0, f3};
        imm      = XLEN'(imm_i);
        imm_en   = 1'b1;
        sel_a    = rs1_w;
        sel_out  = rd_w;
      end
      OP_LUI, OP_AUIPC: begin
        imm      = XLEN'(imm_u);
        imm_en   = 1'b1;
        sel_a    = (opcode == OP_AUIPC) ? PC_SEL : '0;
        sel_out  = rd_w;
      end
      // Link value is computed by the ALU as PC + (-4)
      OP_JAL, OP_JALR: begin
        imm      = LINK_OFF;
        imm_en   = 1'b1;
        sel_a    = PC_SEL;
        sel_out  = rd_w;
        new_jmp  = 1'b1;
        jmp_type = (opcode == OP_JAL) ? JT_JAL : JT_JALR;
        jmp_imm  = (opcode == OP_JAL) ? XLEN'(imm_j) : XLEN'(imm_i);
        jal_rs   = (opcode == OP_JAL) ? PC_SEL : rs1_w;
      end
      OP_B: begin
        case (f3)
          F3_BEQ, F3_BNE:   alu_ctrl = ALU_SUB;
          F3_BLT, F3_BGE:   alu_ctrl = ALU_SLT;
          F3_BLTU, F3_BGEU: alu_ctrl = ALU_SLTU;
          default:          alu_ctrl = ALU_SUB;
        endcase
        sel_a    = rs1_w;
        sel_b    = rs2_n;
        new_jmp  = 1'b1;
        jmp_type = f3;
        jmp_imm  = XLEN'(imm_b);
      end
      OP_LOAD, OP_S: begin
        imm         = (opcode == OP_S) ? XLEN'(imm_s) : XLEN'(imm_i);
        imm_en      = 1'b1;
        sel_a       = rs1_w;
        lam_new     = 1'b1;
        lam_rw      = (opcode == OP_S);
        lam_type    = f3;
        lam_rs      = (opcode == OP_S) ? rs2_n : '0;
        lam_sel_out = (opcode == OP_S) ? '0 : rd_n;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshakes and a wrong-path
// squash window after jumps. DECODE_MEXT_EN enables M-extension decode.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int JMP_DROP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             jmp_cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       alu_ctrl,
  output logic [XLEN-1:0]  imm,
  output logic             imm_en,
  output logic [REG_W:0]   sel_a,
  output logic [REG_W-1:0] sel_b,
  output logic [REG_W:0]   sel_out,
  output logic             new_jmp,
  output logic [2:0]       jmp_type,
  output logic [XLEN-1:0]  jmp_imm,
  output logic [REG_W:0]   jal_rs,
  output logic             lam_new,
  output logic             lam_rw,
  output logic [2:0]       lam_type,
  output logic [REG_W-1:0] lam_rs,
  output logic [REG_W-1:0] lam_sel_out,
  output logic             illegal
);

  localparam int BW    = 2*XLEN + 6*REG_W + 24;
  localparam int CNT_W = $clog2(JMP_DROP + 2);

  logic [9:0]       d_alu_ctrl;
  logic [XLEN-1:0]  d_imm, d_jmp_imm;
  logic             d_imm_en, d_new_jmp, d_lam_new, d_lam_rw, d_illegal;
  logic [REG_W:0]   d_sel_a, d_sel_out, d_jal_rs;
  logic [REG_W-1:0] d_sel_b, d_lam_rs, d_lam_sel_out;
  logic [2:0]       d_jmp_type, d_lam_type;
  logic [BW-1:0]    bundle_d, bundle_q;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             drop_beat, accept;

  decode_comb #(.XLEN(XLEN), .REG_W(REG_W)) u_comb (
    .instr(in_instr), .alu_ctrl(d_alu_ctrl), .imm(d_imm), .imm_en(d_imm_en),
    .sel_a(d_sel_a), .sel_b(d_sel_b), .sel_out(d_sel_out), .new_jmp(d_new_jmp),
    .jmp_type(d_jmp_type), .jmp_imm(d_jmp_imm), .jal_rs(d_jal_rs),
    .lam_new(d_lam_new), .lam_rw(d_lam_rw), .lam_type(d_lam_type),
    .lam_rs(d_lam_rs), .lam_sel_out(d_lam_sel_out), .illegal(d_illegal)
  );

  assign bundle_d = {d_alu_ctrl, d_imm, d_imm_en, d_sel_a, d_sel_b, d_sel_out,
                     d_new_jmp, d_jmp_type, d_jmp_imm, d_jal_rs, d_lam_new,
                     d_lam_rw, d_lam_type, d_lam_rs, d_lam_sel_out, d_illegal};
  assign {alu_ctrl, imm, imm_en, sel_a, sel_b, sel_out, new_jmp, jmp_type,
          jmp_imm, jal_rs, lam_new, lam_rw, lam_type, lam_rs, lam_sel_out,
          illegal} = bundle_q;

  // A cancel ends the squash window in the same cycle, so that beat falls back
  // to the normal handshake and cannot overwrite a bundle still being held.
  assign drop_beat = (state == ST_DROP) && !jmp_cancel;
  assign in_ready  = drop_beat || !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (drop_beat) begin
      if (accept) begin
        if (cnt == CNT_W'(1)) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt - CNT_W'(1);
        end
      end
    end else begin
      state_next = ST_RUN;
      cnt_next   = '0;
      if (accept && d_new_jmp && (JMP_DROP > 0)) begin
        state_next = ST_DROP;
        cnt_next   = CNT_W'(JMP_DROP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      bundle_q  <= '0;
    end else if (accept && !drop_beat) begin
      out_valid <= 1'b1;
      bundle_q  <= bundle_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage against a behavioural
// RV32I decode / squash-window model.
module tb_decode_stage;

  localparam int XLEN     = 32;
  localparam int REG_W    = 5;
  localparam int JMP_DROP = 2;

  logic        clk, rst, in_valid, in_ready, jmp_cancel, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [9:0]  alu_ctrl;
  logic [31:0] imm, jmp_imm;
  logic        imm_en, new_jmp, lam_new, lam_rw, illegal;
  logic [5:0]  sel_a, sel_out, jal_rs;
  logic [4:0]  sel_b, lam_rs, lam_sel_out;
  logic [2:0]  jmp_type, lam_type;

  typedef struct {
    logic [9:0]  alu_ctrl;
    logic [31:0] imm;
    logic        imm_en;
    logic [5:0]  sel_a;
    logic [4:0]  sel_b;
    logic [5:0]  sel_out;
    logic        new_jmp;
    logic [2:0]  jmp_type;
    logic [31:0] jmp_imm;
    logic [5:0]  jal_rs;
    logic        lam_new;
    logic        lam_rw;
    logic [2:0]  lam_type;
    logic [4:0]  lam_rs;
    logic [4:0]  lam_sel_out;
    logic        illegal;
  } bundle_t;

  int      errorCount = 0;
  int      checkCount = 0;
  bundle_t expBundle;
  logic    expValid;
  logic    expZero;
  int      dropLeft;
  bit      mextOn;

  decode_stage #(.XLEN(XLEN), .REG_W(REG_W), .JMP_DROP(JMP_DROP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .jmp_cancel(jmp_cancel), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .imm(imm), .imm_en(imm_en),
    .sel_a(sel_a), .sel_b(sel_b), .sel_out(sel_out), .new_jmp(new_jmp),
    .jmp_type(jmp_type), .jmp_imm(jmp_imm), .jal_rs(jal_rs),
    .lam_new(lam_new), .lam_rw(lam_rw), .lam_type(lam_type),
    .lam_rs(lam_rs), .lam_sel_out(lam_sel_out), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode model written straight from the ISA field definitions
  function automatic bundle_t model(input logic [31:0] ins);
    bundle_t b;
    int op, f3, f7, rd, rs1, rs2, v;
    b = '{default: '0};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
    case (op)
      'h33: begin
        if (f7 == 0 || f7 == 32 || (mextOn && f7 == 1)) begin
          b.alu_ctrl = 10'(f7 * 8 + f3);
          b.sel_a = 6'(rs1); b.sel_b = 5'(rs2); b.sel_out = 6'(rd);
        end else b.illegal = 1'b1;
      end
      'h13: begin
        b.alu_ctrl = (f3 == 1 || f3 == 5) ? 10'(f7 * 8 + f3) : 10'(f3);
        v = $signed(ins[31:20]);
        b.imm = v; b.imm_en = 1; b.sel_a = 6'(rs1); b.sel_out = 6'(rd);
      end
      'h37, 'h17: begin
        b.imm = ins & 32'hFFFF_F000; b.imm_en = 1; b.sel_out = 6'(rd);
        b.sel_a = (op == 'h17) ? 6'd32 : 6'd0;
      end
      'h6F, 'h67: begin
        b.imm = -4; b.imm_en = 1; b.sel_a = 6'd32; b.sel_out = 6'(rd);
        b.new_jmp = 1;
        if (op == 'h6F) begin
          v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
          b.jmp_type = 3'd2; b.jal_rs = 6'd32;
        end else begin
          v = $signed(ins[31:20]);
          b.jmp_type = 3'd3; b.jal_rs = 6'(rs1);
        end
        b.jmp_imm = v;
      end
      'h63: begin
        if (f3 < 4) b.alu_ctrl = 10'h100;
        else if (f3 < 6) b.alu_ctrl = 10'h002;
        else b.alu_ctrl = 10'h003;
        b.sel_a = 6'(rs1); b.sel_b = 5'(rs2);
        b.new_jmp = 1; b.jmp_type = 3'(f3);
        v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        b.jmp_imm = v;
      end
      'h03, 'h23: begin
        if (op == 'h23) begin
          v = $signed({ins[31:25], ins[11:7]});
          b.lam_rw = 1; b.lam_rs = 5'(rs2);
        end else begin
          v = $signed(ins[31:20]);
          b.lam_sel_out = 5'(rd);
        end
        b.imm = v; b.imm_en = 1; b.sel_a = 6'(rs1);
        b.lam_new = 1; b.lam_type = 3'(f3);
      end
      default: b.illegal = 1'b1;
    endcase
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkBundle();
    checkOutput("alu_ctrl", 32'(alu_ctrl), 32'(expBundle.alu_ctrl));
    checkOutput("imm", imm, expBundle.imm);
    checkOutput("imm_en", 32'(imm_en), 32'(expBundle.imm_en));
    checkOutput("sel_a", 32'(sel_a), 32'(expBundle.sel_a));
    checkOutput("sel_b", 32'(sel_b), 32'(expBundle.sel_b));
    checkOutput("sel_out", 32'(sel_out), 32'(expBundle.sel_out));
    checkOutput("new_jmp", 32'(new_jmp), 32'(expBundle.new_jmp));
    checkOutput("jmp_type", 32'(jmp_type), 32'(expBundle.jmp_type));
    checkOutput("jmp_imm", jmp_imm, expBundle.jmp_imm);
    checkOutput("jal_rs", 32'(jal_rs), 32'(expBundle.jal_rs));
    checkOutput("lam_new", 32'(lam_new), 32'(expBundle.lam_new));
    checkOutput("lam_rw", 32'(lam_rw), 32'(expBundle.lam_rw));
    checkOutput("lam_type", 32'(lam_type), 32'(expBundle.lam_type));
    checkOutput("lam_rs", 32'(lam_rs), 32'(expBundle.lam_rs));
    checkOutput("lam_sel_out", 32'(lam_sel_out), 32'(expBundle.lam_sel_out));
    checkOutput("illegal", 32'(illegal), 32'(expBundle.illegal));
  endtask

  // One clock cycle: check registered outputs, drive inputs, advance the model
  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic ordy, input logic canc, input logic r);
    logic dropping, expReady, acc;
    @(negedge clk);
    checkOutput("out_valid", 32'(out_valid), 32'(expValid));
    if (expValid || expZero) checkBundle();
    rst = r; in_valid = v; in_instr = ins; out_ready = ordy; jmp_cancel = canc;
    #1;
    dropping = (dropLeft > 0) && !canc;
    expReady = dropping || !expValid || ordy;
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    if (r) begin
      expValid = 0; expZero = 1; dropLeft = 0; expBundle = '{default: '0};
    end else begin
      acc = v && expReady;
      if (canc) dropLeft = 0;
      if (acc && !dropping) begin
        expBundle = model(ins); expValid = 1; expZero = 0;
        if (expBundle.new_jmp) dropLeft = JMP_DROP;
      end else if (ordy) begin
        expValid = 0;
      end
      if (acc && dropping) dropLeft--;
    end
  endtask

  function automatic logic [31:0] genInstr();
    logic [31:0] ins;
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};
    int k;
    ins = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) ins[6:0] = ops[k];
    if (ins[6:0] == 7'h33 || (ins[6:0] == 7'h13 && ins[13:12] == 2'b01))
      ins[31:25] = f7s[$urandom_range(0, 3)];
    return ins;
  endfunction

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] BEQ  = 32'h0020_8463;
  localparam logic [31:0] JAL  = 32'h0080_00EF;
  localparam logic [31:0] LW   = 32'h0041_2283;
  localparam logic [31:0] MUL  = 32'h0220_81B3;

  initial begin
`ifdef DECODE_MEXT_EN
    mextOn = 1'b1;
`else
    mextOn = 1'b0;
`endif
    rst = 1; in_valid = 0; in_instr = '0; out_ready = 0; jmp_cancel = 0;
    repeat (2) @(posedge clk);
    expValid = 0; expZero = 1; dropLeft = 0; expBundle = '{default: '0};

    $display("[TB] directed sequences");
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, ADDI, 1, 0, 0);
    applyStimulus(1, ADD, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, BEQ, 1, 0, 0);
    repeat (3) applyStimulus(1, ADDI, 1, 0, 0);
    applyStimulus(1, JAL, 1, 0, 0);
    applyStimulus(1, ADDI, 1, 1, 0);
    applyStimulus(1, LW, 1, 0, 0);
    applyStimulus(1, MUL, 1, 0, 0);
    applyStimulus(1, BEQ, 0, 0, 0);
    applyStimulus(1, ADDI, 0, 0, 0);
    applyStimulus(1, ADDI, 1, 0, 1);
    applyStimulus(1, ADDI, 1, 0, 0);
    applyStimulus(1, JAL, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, genInstr(), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    applyStimulus(0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
